// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit-instruction core front end:
// special encodings, the fetch FSM state type and a decode helper.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR  = 16'h0000;
  localparam logic [15:0] HALT_INSTR = 16'hFFFF;
  localparam logic [3:0]  BR_OPCODE  = 4'b1101;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT_BR = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  // True when the halfword carries the branch opcode in its top nibble.
  function automatic logic is_branch(input logic [15:0] instr);
    return instr[15:12] == BR_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus between the fetch sequencer (master) and the
// instruction memory (slave).
//
// Handshake: imem_req is the master's valid, imem_ack the slave's ready.
// A transfer completes in exactly the cycles where imem_req && imem_ack;
// imem_rdata is only meaningful in such a cycle and imem_addr is stable
// while imem_req is held. The slave may ack in the same cycle as the
// request (zero-wait). An ack without a request is ignored, and the master
// may drop a request without an ack (the fetch is then abandoned).
interface fetch_sequencer_if #(
  parameter int AW = 10
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_history.sv
// History of issued PCs, one slot per pipeline step after issue.
// Slot 0 holds the PC in Decode, slot DEPTH-1 the PC in the stage where
// branches resolve; steps without an issue shift in a zero bubble.
module fetch_pc_history #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  output logic [31:0] oldest_pc
);

  logic [31:0] hist [DEPTH];

  // Shift one slot per advancing cycle; frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (advance) begin
      hist[0] <= in_valid ? in_pc : 32'h0;
      for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  assign oldest_pc = hist[DEPTH-1];

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, fetches halfwords over the imem
// req/ack bus, issues one instruction per cycle to Decode, interlocks on
// branches until Execute resolves them and stops on the halt instruction.
// Optional build macro FETCH_PERF_CNT_EN adds issued/stall counters.
//
// Timing of a branch: the branch counter is loaded with BRANCH_LAT at the
// edge that issues the branch and ticks once per non-stalled cycle, so the
// resolve cycle (counter 0 in WAIT_BR) lies BRANCH_LAT cycles after the
// cycle in which instr_valid shows the branch. The FSM leaves FETCH one
// cycle after issue, so any fetch completing in that cycle is dropped.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int          IMEM_AW    = 10,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          BRANCH_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master imem,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic [31:0]       issue_pc,
  input  logic              branch_taken,
  input  logic [31:0]       delta_instruction,
  input  logic              global_disable,
  output logic              halt,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       issued_count,
  output logic [31:0]       stall_count,
`endif
  output fetch_state_t      fsm_state
);

  localparam int CW = $clog2(BRANCH_LAT + 1);

  fetch_state_t  state, state_nx;
  logic [31:0]   pc;
  logic          skid_valid;
  logic [15:0]   skid_data;
  logic [CW-1:0] br_cnt;
  logic [31:0]   branch_pc;

  logic          req_c;
  logic          issue_en;
  logic [15:0]   issue_data;
  logic          skid_wr;
  logic          skid_rd;
  logic          resolve;
  logic          advance;

  // The pipeline behind us only stalls branch timing while waiting on Execute.
  assign advance = !(state == WAIT_BR && global_disable);

  fetch_pc_history #(.DEPTH(BRANCH_LAT)) u_hist (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .in_valid  (instr_valid),
    .in_pc     (issue_pc),
    .oldest_pc (branch_pc)
  );

  // Next state, issue selection and skid control.
  always_comb begin
    state_nx   = state;
    req_c      = 1'b0;
    issue_en   = 1'b0;
    issue_data = NOP_INSTR;
    skid_wr    = 1'b0;
    skid_rd    = 1'b0;
    resolve    = 1'b0;
    case (state)
      FETCH: begin
        req_c = !skid_valid;
        if (instr_valid && instruction == HALT_INSTR) begin
          state_nx = HALTED;
        end else if (instr_valid && is_branch(instruction)) begin
          state_nx = WAIT_BR;
        end else if (skid_valid) begin
          if (!global_disable) begin
            issue_en   = 1'b1;
            issue_data = skid_data;
            skid_rd    = 1'b1;
          end
        end else if (imem.imem_ack) begin
          if (global_disable) begin
            skid_wr = 1'b1;
          end else begin
            issue_en   = 1'b1;
            issue_data = imem.imem_rdata;
          end
        end
      end
      WAIT_BR: begin
        if (!global_disable && br_cnt == '0) begin
          resolve  = 1'b1;
          state_nx = FETCH;
        end
      end
      HALTED: begin
        state_nx = HALTED;
      end
      default: state_nx = FETCH;
    endcase
  end

  // State, PC, issue registers, skid buffer and branch counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      instr_valid <= 1'b0;
      issue_pc    <= 32'h0;
      skid_valid  <= 1'b0;
      skid_data   <= NOP_INSTR;
      br_cnt      <= '0;
    end else begin
      state       <= state_nx;
      instr_valid <= issue_en;
      instruction <= issue_en ? issue_data : NOP_INSTR;
      if (issue_en) begin
        issue_pc <= pc;
        pc       <= pc + 32'd1;
      end else if (resolve && branch_taken) begin
        pc <= branch_pc + delta_instruction;
      end
      if (skid_wr) begin
        skid_valid <= 1'b1;
        skid_data  <= imem.imem_rdata;
      end else if (skid_rd) begin
        skid_valid <= 1'b0;
      end
      if (issue_en && is_branch(issue_data)) begin
        br_cnt <= CW'(BRANCH_LAT);
      end else if (advance && br_cnt != '0) begin
        br_cnt <= br_cnt - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issued_count <= 32'h0;
      stall_count  <= 32'h0;
    end else begin
      if (instr_valid) issued_count <= issued_count + 32'd1;
      if (global_disable && (state == FETCH || state == WAIT_BR))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

  assign imem.imem_req  = reset && req_c;
  assign imem.imem_addr = pc[IMEM_AW-1:0];
  assign halt           = (state == HALTED);
  assign fsm_state      = state;

endmodule
